sync_fifo_flags: RTL

- Parametrised synchronous single-clock FIFO. Successor to the team's fixed 3-bit/4-deep FIFO.
- Adds:
  - generic width/depth
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - selectable standard or first-word-fall-through (FWFT) read mode
  - rd_valid qualifier
  - optional sticky overflow/underflow error status
- Sits between producer/consumer datapaths in the same clock domain.

---
 rtl/sync_fifo_flags.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and standard or first-word-fall-through read. Define SYNC_FIFO_ERR_EN for sticky overflow/underflow status.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
`ifdef SYNC_FIFO_ERR_EN
  input  logic                     clr_err,
  output logic                     overflow,
  output logic                     underflow,
`endif
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Status flags and accept decisions from the registered occupancy
  always_comb begin
    full_s   = (count_r == DEPTH_C);
    empty_s  = (count_r == {PW{1'b0}});
    wr_acc_s = wr_en && !full_s;
    rd_acc_s = rd_en && !empty_s;
  end

  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign count        = count_r;

  // Storage write; the array is deliberately left uninitialised by reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointer and occupancy update; pointers carry a wrap bit above the index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {PW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + PW'(1);
        2'b01:   count_r <= count_r - PW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];
      assign rd_valid = !empty_s;
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_r;
      logic             rd_valid_r;

      // Registered read: data lands one cycle after the accepted request
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_r  <= {WIDTH{1'b0}};
          rd_valid_r <= 1'b0;
        end else begin
          rd_valid_r <= rd_acc_s;
          if (rd_acc_s) begin
            rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
          end
        end
      end

      assign rd_data  = rd_data_r;
      assign rd_valid = rd_valid_r;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error status; a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && full_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule
